// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller and its interface.
package hazard_ctrl_pkg;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;
   localparam int LU_CNT_W = 4;

   typedef enum logic {
      RUN      = 1'b0,
      LU_STALL = 1'b1
   } hz_state_t;

   // Source operand hits the load destination only when the instruction actually reads it.
   function automatic logic src_hits_rd(input logic                  use_src,
                                        input logic [REG_ADDR_W-1:0] src,
                                        input logic [REG_ADDR_W-1:0] rd);
      return use_src && (src == rd);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller signal bundle. Perf counter ports exist only with HAZARD_PERF_EN.
interface hazard_ctrl_if
`ifdef HAZARD_PERF_EN
   #(parameter int CNT_W = 16)
`endif
   ;
   import hazard_ctrl_pkg::*;

   logic [REG_ADDR_W-1:0] ifid_rs1_i;
   logic [REG_ADDR_W-1:0] ifid_rs2_i;
   logic                  id_use_rs1_i;
   logic                  id_use_rs2_i;
   logic                  id_branch_taken_i;
   logic                  idex_memread_i;
   logic [REG_ADDR_W-1:0] idex_rd_i;
   logic                  dmem_req_i;
   logic                  dmem_ack_i;
   logic                  pc_write_o;
   logic                  ifid_stall_o;
   logic                  ifid_flush_o;
   logic                  idex_bubble_o;
   logic                  pipe_freeze_o;
   logic                  state_o;
`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0]      stall_cnt_o;
   logic [CNT_W-1:0]      flush_cnt_o;
`endif

   modport master (
      output ifid_rs1_i, ifid_rs2_i, id_use_rs1_i, id_use_rs2_i, id_branch_taken_i,
      output idex_memread_i, idex_rd_i, dmem_req_i, dmem_ack_i,
      input  pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o, state_o
`ifdef HAZARD_PERF_EN
      , input stall_cnt_o, flush_cnt_o
`endif
   );

   modport slave (
      input  ifid_rs1_i, ifid_rs2_i, id_use_rs1_i, id_use_rs2_i, id_branch_taken_i,
      input  idex_memread_i, idex_rd_i, dmem_req_i, dmem_ack_i,
      output pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o, state_o
`ifdef HAZARD_PERF_EN
      , output stall_cnt_o, flush_cnt_o
`endif
   );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for stall/flush statistics (HAZARD_PERF_EN builds).
module hazard_perf_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != {CNT_W{1'b1}})) begin
         cnt_o <= cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/freeze generator for the 5-stage pipeline; Mealy outputs from state, count and inputs.
// Optional stall/flush perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int LOAD_STALL_CYC = 1,
   parameter int CNT_W          = 16
) (
   input logic         clk_i,
   input logic         rst_n_i,
   hazard_ctrl_if.slave hif
);

   localparam logic [LU_CNT_W-1:0] LU_RELOAD = LU_CNT_W'(LOAD_STALL_CYC - 1);

   if ((LOAD_STALL_CYC < 1) || (LOAD_STALL_CYC > 15) || (CNT_W < 1)) begin : g_param_check
      $error("hazard_ctrl: LOAD_STALL_CYC must be 1..15 and CNT_W at least 1");
   end

   hz_state_t             state_reg, state_next;
   logic [LU_CNT_W-1:0]   lu_cnt_reg, lu_cnt_next;
   logic                  freeze, hazard;
   logic                  pc_write, stall, flush, bubble;
   logic [REG_ADDR_W-1:0] src_addr [2];
   logic [1:0]            src_use;
   logic [1:0]            src_hit;

   assign src_addr[0] = hif.ifid_rs1_i;
   assign src_addr[1] = hif.ifid_rs2_i;
   assign src_use     = {hif.id_use_rs2_i, hif.id_use_rs1_i};

   for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_hits_rd(src_use[gi], src_addr[gi], hif.idex_rd_i);
   end

   assign freeze = hif.dmem_req_i & ~hif.dmem_ack_i;
   assign hazard = hif.idex_memread_i & (hif.idex_rd_i != REG_X0) & (|src_hit);

   always_comb begin
      state_next  = state_reg;
      lu_cnt_next = lu_cnt_reg;
      pc_write    = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      bubble      = 1'b0;
      if (freeze) begin
         stall = 1'b1;
      end else if (state_reg == LU_STALL) begin
         // Branch outcome is ignored here: its operands come from the load still in flight.
         stall  = 1'b1;
         bubble = 1'b1;
         if (lu_cnt_reg == LU_CNT_W'(1)) begin
            state_next  = RUN;
            lu_cnt_next = '0;
         end else begin
            lu_cnt_next = lu_cnt_reg - LU_CNT_W'(1);
         end
      end else if (hazard) begin
         stall  = 1'b1;
         bubble = 1'b1;
         if (LOAD_STALL_CYC > 1) begin
            state_next  = LU_STALL;
            lu_cnt_next = LU_RELOAD;
         end
      end else begin
         pc_write = 1'b1;
         flush    = hif.id_branch_taken_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_reg  <= RUN;
         lu_cnt_reg <= '0;
      end else begin
         state_reg  <= state_next;
         lu_cnt_reg <= lu_cnt_next;
      end
   end

   // Gating with reset keeps every control low while reset is held, with no edge needed.
   assign hif.pc_write_o    = rst_n_i & pc_write;
   assign hif.ifid_stall_o  = rst_n_i & stall;
   assign hif.ifid_flush_o  = rst_n_i & flush;
   assign hif.idex_bubble_o = rst_n_i & bubble;
   assign hif.pipe_freeze_o = rst_n_i & freeze;
   assign hif.state_o       = rst_n_i & (state_reg == LU_STALL);

`ifdef HAZARD_PERF_EN
   logic [1:0]       perf_inc;
   logic [CNT_W-1:0] perf_cnt [2];

   assign perf_inc = {rst_n_i & flush, rst_n_i & stall};

   for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .inc_i   (perf_inc[gi]),
         .cnt_o   (perf_cnt[gi])
      );
   end

   assign hif.stall_cnt_o = perf_cnt[0];
   assign hif.flush_cnt_o = perf_cnt[1];
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 3 bubble cycles) share stimulus; HAZARD_PERF_EN adds counter checks.
module tb_hazard_ctrl;

    localparam int CMAX = 3;   // all-ones of the 2-bit perf counters used here

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       memread = 1'b0, use1 = 1'b0, use2 = 1'b0, br = 1'b0, req = 1'b0, ack = 1'b0;
    logic [4:0] rd = '0, rs1 = '0, rs2 = '0;

`ifdef HAZARD_PERF_EN
    hazard_ctrl_if #(.CNT_W(2)) hif1 ();
    hazard_ctrl_if #(.CNT_W(2)) hif3 ();
`else
    hazard_ctrl_if hif1 ();
    hazard_ctrl_if hif3 ();
`endif

    assign hif1.ifid_rs1_i = rs1;       assign hif3.ifid_rs1_i = rs1;
    assign hif1.ifid_rs2_i = rs2;       assign hif3.ifid_rs2_i = rs2;
    assign hif1.id_use_rs1_i = use1;    assign hif3.id_use_rs1_i = use1;
    assign hif1.id_use_rs2_i = use2;    assign hif3.id_use_rs2_i = use2;
    assign hif1.id_branch_taken_i = br; assign hif3.id_branch_taken_i = br;
    assign hif1.idex_memread_i = memread; assign hif3.idex_memread_i = memread;
    assign hif1.idex_rd_i = rd;         assign hif3.idex_rd_i = rd;
    assign hif1.dmem_req_i = req;       assign hif3.dmem_req_i = req;
    assign hif1.dmem_ack_i = ack;       assign hif3.dmem_ack_i = ack;

    hazard_ctrl #(.LOAD_STALL_CYC(1), .CNT_W(2)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .hif(hif1));
    hazard_ctrl #(.LOAD_STALL_CYC(3), .CNT_W(2)) dut3 (.clk_i(clk), .rst_n_i(rst_n), .hif(hif3));

    // {pc_write, stall, flush, bubble, freeze, state}
    logic [5:0] out1, out3;
    assign out1 = {hif1.pc_write_o, hif1.ifid_stall_o, hif1.ifid_flush_o,
                   hif1.idex_bubble_o, hif1.pipe_freeze_o, hif1.state_o};
    assign out3 = {hif3.pc_write_o, hif3.ifid_stall_o, hif3.ifid_flush_o,
                   hif3.idex_bubble_o, hif3.pipe_freeze_o, hif3.state_o};

    localparam logic [5:0] O_IDLE = 6'b100000, O_HZ = 6'b010100, O_LU = 6'b010101;
    localparam logic [5:0] O_BR = 6'b101000, O_FZ0 = 6'b010010, O_FZ1 = 6'b010011;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: rem = bubble cycles still owed after the current cycle's decision.
    int n_stall [2] = '{1, 3};
    int rem     [2] = '{0, 0};
    int st_cnt  [2] = '{0, 0};
    int fl_cnt  [2] = '{0, 0};

    function automatic logic model_hazard();
        return memread && (rd != 5'd0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
    endfunction

    function automatic logic [5:0] model_out(input int k);
        logic lu;
        lu = (rem[k] > 0);
        if (!rst_n)                 return 6'b000000;
        if (req && !ack)            return {5'b01001, lu};
        if (lu)                     return O_LU;
        if (model_hazard())         return O_HZ;
        if (br)                     return O_BR;
        return O_IDLE;
    endfunction

    always @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                logic [5:0] o;
                o = model_out(k);
                if (o[4] && st_cnt[k] < CMAX) st_cnt[k]++;
                if (o[3] && fl_cnt[k] < CMAX) fl_cnt[k]++;
                if (!(req && !ack)) begin
                    if (rem[k] > 0)          rem[k]--;
                    else if (model_hazard()) rem[k] = n_stall[k] - 1;
                end
            end
        end
    end

    always @(negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; st_cnt[k] = 0; fl_cnt[k] = 0;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        n_tests += 2;
        if (out1 !== model_out(0)) begin
            n_fail++;
            $display("FAIL cycle dut1 t=%0t: got %b want %b", $time, out1, model_out(0));
        end
        if (out3 !== model_out(1)) begin
            n_fail++;
            $display("FAIL cycle dut3 t=%0t: got %b want %b", $time, out3, model_out(1));
        end
`ifdef HAZARD_PERF_EN
        n_tests += 4;
        if (hif1.stall_cnt_o !== 2'(st_cnt[0]) || hif1.flush_cnt_o !== 2'(fl_cnt[0])) begin
            n_fail++;
            $display("FAIL perf dut1 t=%0t: got stall=%0d flush=%0d want %0d %0d",
                     $time, hif1.stall_cnt_o, hif1.flush_cnt_o, st_cnt[0], fl_cnt[0]);
        end
        if (hif3.stall_cnt_o !== 2'(st_cnt[1]) || hif3.flush_cnt_o !== 2'(fl_cnt[1])) begin
            n_fail++;
            $display("FAIL perf dut3 t=%0t: got stall=%0d flush=%0d want %0d %0d",
                     $time, hif3.stall_cnt_o, hif3.flush_cnt_o, st_cnt[1], fl_cnt[1]);
        end
`endif
    end

    task automatic expect2(input string name, input logic [5:0] e1, input logic [5:0] e3);
        n_tests += 4;
        if (out1 !== e1) begin
            n_fail++;
            $display("FAIL %s dut1: got %b want %b", name, out1, e1);
        end
        if (out3 !== e3) begin
            n_fail++;
            $display("FAIL %s dut3: got %b want %b", name, out3, e3);
        end
        if (model_out(0) !== e1 || model_out(1) !== e3) begin
            n_fail++;
            $display("FAIL %s model: got %b/%b want %b/%b", name, model_out(0), model_out(1), e1, e3);
        end
        n_tests--;
    endtask

    task automatic step(input string name, input logic mr, input logic [4:0] rd_v,
                        input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic u1,
                        input logic u2, input logic br_v, input logic req_v, input logic ack_v,
                        input logic [5:0] e1, input logic [5:0] e3);
        @(posedge clk); #1;
        memread = mr; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v; use1 = u1; use2 = u2;
        br = br_v; req = req_v; ack = ack_v;
        #1;
        expect2(name, e1, e3);
        $display("[TB] %-10s out1=%b out3=%b", name, out1, out3);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd5;
            2: return 5'd7;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #2 expect2("reset", 6'b0, 6'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        step("idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_IDLE);
        step("lu_hz",    1, 5, 5, 0, 1, 0, 0, 0, 0, O_HZ,   O_HZ);
        step("lu_2",     0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_LU);
        step("lu_3",     0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_LU);
        step("lu_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_IDLE);
        step("rd_x0",    1, 0, 0, 0, 1, 0, 0, 0, 0, O_IDLE, O_IDLE);
        step("rs2_unused", 1, 7, 0, 7, 0, 0, 0, 0, 0, O_IDLE, O_IDLE);
        step("branch",   0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR,   O_BR);
        step("br_hz",    1, 5, 0, 5, 0, 1, 1, 0, 0, O_HZ,   O_HZ);
        step("br_lu2",   0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR,   O_LU);
        step("br_lu3",   0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR,   O_LU);
        step("br_again", 0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR,   O_BR);
        step("fz_hz",    1, 9, 9, 0, 1, 0, 0, 0, 0, O_HZ,   O_HZ);
        for (int i = 0; i < 4; i++)
            step("freeze",   0, 0, 0, 0, 0, 0, 0, 1, 0, O_FZ0,  O_FZ1);
        step("ack",      0, 0, 0, 0, 0, 0, 0, 1, 1, O_IDLE, O_LU);
        step("fz_lu3",   0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_LU);
        step("fz_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_IDLE);
        step("rst_hz",   1, 5, 5, 0, 1, 0, 0, 0, 0, O_HZ,   O_HZ);
        step("rst_lu",   0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_LU);
        #1 rst_n = 1'b0;
        #1 expect2("async_rst", 6'b0, 6'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1 expect2("post_rst", O_IDLE, O_IDLE);

        step("sat_hz_a", 1, 5, 5, 0, 1, 0, 0, 0, 0, O_HZ,   O_HZ);
        step("sat_lu_a", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_LU);
        step("sat_lu_b", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_LU);
        step("sat_hz_b", 1, 5, 5, 0, 1, 0, 0, 0, 0, O_HZ,   O_HZ);
        step("sat_lu_c", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_LU);
        step("sat_lu_d", 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_LU);
        step("sat_end",  0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_IDLE);
`ifdef HAZARD_PERF_EN
        n_tests += 2;
        if (hif3.stall_cnt_o !== 2'd3) begin
            n_fail++;
            $display("FAIL stall_sat dut3: got %0d want 3", hif3.stall_cnt_o);
        end
        if (hif1.stall_cnt_o !== 2'd2) begin
            n_fail++;
            $display("FAIL stall_cnt dut1: got %0d want 2", hif1.stall_cnt_o);
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst_n   = 1'b1;
            memread = 1'($urandom_range(0, 1));
            rd      = pick_reg();
            rs1     = pick_reg();
            rs2     = pick_reg();
            use1    = 1'($urandom_range(0, 1));
            use2    = 1'($urandom_range(0, 1));
            br      = ($urandom_range(0, 3) == 0);
            req     = ($urandom_range(0, 3) == 0);
            ack     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
            end
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #6;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
